// File: rtl/alu_uart_if_pkg.sv
// Shared ALU opcode encodings, frame FSM state encoding and opcode validity helper.
// Used by alu_uart_if and by the ALU itself.
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_B    = 3'd1,
    ST_GET_OP   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SEND_RES = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_SEND_FLG = 3'd6,
    ST_WAIT_FLG = 3'd7
  } state_e;

  function automatic logic is_alu_op(input logic [OP_W-1:0] code);
    logic ok;
    case (code)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_uart_if_if.sv
// Byte/ALU bus between the UART frame controller (slave) and its environment (master).
interface alu_uart_if_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_alu_carry;
  logic               o_error;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_carry,
    output o_tx_data, o_tx_start, o_alu_a, o_alu_b, o_alu_op, o_error
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_carry,
    input  o_tx_data, o_tx_start, o_alu_a, o_alu_b, o_alu_op, o_error
  );
endinterface

// File: rtl/alu_uart_if_frame_timer.sv
// Inter-byte idle counter: clears on request, counts while enabled, flags TIMEOUT-1 reached.
module frame_timer #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_limit;

  assign at_limit = (count_q == LIMIT);
  assign expire_o = enable_i && at_limit;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !at_limit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/alu_uart_if.sv
// UART frame controller: collects A, B, OP bytes, drives the ALU and transmits the result.
// Define ALU_UART_IF_CARRY_TX_EN to also transmit a carry flag byte after the result.
module alu_uart_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  alu_uart_if_if.slave  bus
);
  import alu_pkg::*;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               error_q, error_d;
  logic               timer_clear, timer_en, timer_expire;
  logic               op_valid;

`ifdef ALU_UART_IF_CARRY_TX_EN
  logic               carry_q, carry_d;
`else
  logic               unused_carry;
  assign unused_carry = bus.i_alu_carry;
`endif

  frame_timer #(.TIMEOUT(TIMEOUT)) u_frame_timer (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  // Opcode byte must have all bits above the opcode field clear.
  assign op_valid = (bus.i_rx_data[NB_DATA-1:OP_W] == '0) &&
                    is_alu_op(bus.i_rx_data[OP_W-1:0]);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tx_data_d   = tx_data_q;
    error_d     = 1'b0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
`ifdef ALU_UART_IF_CARRY_TX_EN
    carry_d     = carry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.i_rx_done) begin
          a_d     = bus.i_rx_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        timer_clear = bus.i_rx_done;
        timer_en    = 1'b1;
        if (bus.i_rx_done) begin
          b_d     = bus.i_rx_data;
          state_d = ST_GET_OP;
        end else if (timer_expire) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GET_OP: begin
        timer_clear = bus.i_rx_done;
        timer_en    = 1'b1;
        if (bus.i_rx_done) begin
          if (op_valid) begin
            op_d    = NB_OP'(bus.i_rx_data[OP_W-1:0]);
            state_d = ST_EXEC;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timer_expire) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        tx_data_d = bus.i_alu_result;
`ifdef ALU_UART_IF_CARRY_TX_EN
        carry_d   = bus.i_alu_carry;
`endif
        state_d   = ST_SEND_RES;
      end
      ST_SEND_RES: state_d = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (bus.i_tx_done) begin
`ifdef ALU_UART_IF_CARRY_TX_EN
          tx_data_d = NB_DATA'(carry_q);
          state_d   = ST_SEND_FLG;
`else
          state_d   = ST_IDLE;
`endif
        end
      end
`ifdef ALU_UART_IF_CARRY_TX_EN
      ST_SEND_FLG: state_d = ST_WAIT_FLG;
      ST_WAIT_FLG: begin
        if (bus.i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Start pulse is registered so it is high exactly while in a SEND state.
    tx_start_d = (state_d == ST_SEND_RES) || (state_d == ST_SEND_FLG);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      error_q    <= 1'b0;
`ifdef ALU_UART_IF_CARRY_TX_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      error_q    <= error_d;
`ifdef ALU_UART_IF_CARRY_TX_EN
      carry_q    <= carry_d;
`endif
    end
  end

  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_error    = error_q;
endmodule

// File: tb/tb_alu_uart_if.sv
// Directed bench for alu_uart_if: behavioural ALU, expected-byte scoreboard, frame/error/timeout/reset cases.
module tb_alu_uart_if;

  localparam int unsigned TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_uart_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_if #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Behavioural ALU fed from the registered operands.
  logic [8:0] alu_w;
  always_comb begin
    alu_w = 9'd0;
    case (bus.o_alu_op)
      6'h20:   alu_w = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
      6'h22:   alu_w = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
      6'h24:   alu_w = {1'b0, bus.o_alu_a & bus.o_alu_b};
      6'h25:   alu_w = {1'b0, bus.o_alu_a | bus.o_alu_b};
      6'h26:   alu_w = {1'b0, bus.o_alu_a ^ bus.o_alu_b};
      6'h27:   alu_w = {1'b0, ~(bus.o_alu_a | bus.o_alu_b)};
      6'h03:   alu_w = {1'b0, 8'($signed(bus.o_alu_a) >>> bus.o_alu_b)};
      6'h02:   alu_w = {1'b0, bus.o_alu_a >> bus.o_alu_b};
      default: alu_w = 9'd0;
    endcase
    bus.i_alu_result = alu_w[7:0];
    bus.i_alu_carry  = alu_w[8];
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int n_starts = 0;
  int exp_starts = 0;
  logic [7:0] sb[$];

  always @(negedge clk) begin
    if (bus.o_tx_start) n_starts <= n_starts + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1;
    bus.i_tx_done = 1'b1;
    @(posedge clk); #1;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic push_expect(input logic [7:0] res, input logic [7:0] flg);
    sb.push_back(res);
    exp_starts++;
`ifdef ALU_UART_IF_CARRY_TX_EN
    sb.push_back(flg);
    exp_starts++;
`else
    if (flg !== 8'h00 && flg !== 8'h01) $display("note: unexpected flag value %0h", flg);
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_a"},     32'(bus.o_alu_a),    32'h0);
    chk({tag, "_b"},     32'(bus.o_alu_b),    32'h0);
    chk({tag, "_op"},    32'(bus.o_alu_op),   32'h0);
    chk({tag, "_txd"},   32'(bus.o_tx_data),  32'h0);
    chk({tag, "_start"}, 32'(bus.o_tx_start), 32'h0);
    chk({tag, "_err"},   32'(bus.o_error),    32'h0);
  endtask

  // Called right after the OP byte has been sampled.
  task automatic complete_frame(input logic [7:0] a_exp, input bit poke);
    logic [7:0] e;
    @(negedge clk);
    chk("exec_no_start", 32'(bus.o_tx_start), 32'h0);
    @(negedge clk);
    chk("send_start", 32'(bus.o_tx_start), 32'h1);
    e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    chk("sb_tx_data", 32'(bus.o_tx_data), 32'(e));
    if (poke) begin
      send_byte(8'hAA);
      @(negedge clk);
      chk("poke_a_hold", 32'(bus.o_alu_a), 32'(a_exp));
      chk("poke_no_err", 32'(bus.o_error), 32'h0);
    end
    repeat (2) @(negedge clk);
    chk("wait_hold", 32'(bus.o_tx_data), 32'(e));
    chk("wait_no_start", 32'(bus.o_tx_start), 32'h0);
    pulse_tx_done();
`ifdef ALU_UART_IF_CARRY_TX_EN
    @(negedge clk);
    chk("flg_start", 32'(bus.o_tx_start), 32'h1);
    e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    chk("sb_flg_data", 32'(bus.o_tx_data), 32'(e));
    pulse_tx_done();
`endif
    @(negedge clk);
    chk("post_no_start", 32'(bus.o_tx_start), 32'h0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] res, input logic [7:0] flg, input bit poke);
    push_expect(res, flg);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    complete_frame(a, poke);
    chk("op_loaded", 32'(bus.o_alu_op), 32'(op[5:0]));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'hCC, 8'hAA, 8'h24, 8'h88},
    '{8'hCC, 8'hAA, 8'h26, 8'h66},
    '{8'hCC, 8'hAA, 8'h27, 8'h11},
    '{8'h80, 8'h03, 8'h03, 8'hF0},
    '{8'h80, 8'h03, 8'h02, 8'h10}
  };

  initial begin
    bus.i_rx_data = 8'h77;
    bus.i_rx_done = 1'b1;
    bus.i_tx_done = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_rx_done = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // Stray tx_done in IDLE
    pulse_tx_done();
    @(negedge clk);
    chk("idle_txdone_no_start", 32'(bus.o_tx_start), 32'h0);

    run_frame(8'hFF, 8'h01, 8'h20, 8'h00, 8'h01, 1'b0);
    run_frame(8'h03, 8'h05, 8'h22, 8'hFE, 8'h01, 1'b1);

    // Invalid opcode drops the frame
    send_byte(8'h0F);
    send_byte(8'hF0);
    send_byte(8'h3F);
    @(negedge clk);
    chk("inv_err", 32'(bus.o_error), 32'h1);
    chk("inv_op_hold", 32'(bus.o_alu_op), 32'h22);
    chk("inv_no_start", 32'(bus.o_tx_start), 32'h0);
    @(negedge clk);
    chk("inv_err_pulse", 32'(bus.o_error), 32'h0);
    chk("inv_a", 32'(bus.o_alu_a), 32'h0F);
    chk("inv_b", 32'(bus.o_alu_b), 32'hF0);
    run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00, 1'b0);

    foreach (vecs[i]) run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_a", 32'(bus.o_alu_a), 32'h80);
    chk("hold_b", 32'(bus.o_alu_b), 32'h03);
    chk("hold_op", 32'(bus.o_alu_op), 32'h02);

    // Timeout after A byte
    send_byte(8'h12);
    repeat (TO) @(negedge clk);
    chk("to_no_err_early", 32'(bus.o_error), 32'h0);
    @(negedge clk);
    chk("to_err", 32'(bus.o_error), 32'h1);
    @(negedge clk);
    chk("to_err_pulse", 32'(bus.o_error), 32'h0);
    chk("to_a", 32'(bus.o_alu_a), 32'h12);
    run_frame(8'h01, 8'h02, 8'h20, 8'h03, 8'h00, 1'b0);

    // Byte arriving on the expiry cycle wins
    push_expect(8'h05, 8'h00);
    send_byte(8'h09);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h04);
    @(negedge clk);
    chk("boundary_no_err", 32'(bus.o_error), 32'h0);
    chk("boundary_b", 32'(bus.o_alu_b), 32'h04);
    repeat (TO - 3) @(posedge clk);
    send_byte(8'h22);
    complete_frame(8'h09, 1'b0);

    // Reset in GET_OP with a coincident byte
    send_byte(8'h55);
    send_byte(8'h66);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_rx_data = 8'h20;
    bus.i_rx_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_rx_done = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (4) @(negedge clk);
    chk("midreset_no_start", 32'(bus.o_tx_start), 32'h0);
    run_frame(8'h07, 8'h01, 8'h22, 8'h06, 8'h00, 1'b0);
    chk("post_reset_a", 32'(bus.o_alu_a), 32'h07);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("start_count", 32'(n_starts), 32'(exp_starts));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, operand/result width in bits.
REQ-002 The block SHALL have parameter NB_OP, default 6, ALU opcode width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 100000, idle clock cycles allowed between bytes of one frame.
REQ-004 The block SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, reset; one clock, synchronous, active-high.
REQ-006 The block SHALL have port i_rx_data, input, NB_DATA, byte from UART receiver.
REQ-007 The block SHALL have port i_rx_done, input, 1, one-cycle pulse qualifying i_rx_data.
REQ-008 The block SHALL have port i_tx_done, input, 1, one-cycle pulse when the transmitter finishes a byte.
REQ-009 The block SHALL have port o_tx_data, output, NB_DATA, byte to transmit.
REQ-010 The block SHALL have port o_tx_start, output, 1, one-cycle transmit request.
REQ-011 The block SHALL have ports o_alu_a and o_alu_b, output, NB_DATA each, and o_alu_op, output, NB_OP, registered ALU operands and opcode.
REQ-012 The block SHALL have ports i_alu_result, input, NB_DATA, and i_alu_carry, input, 1, from the combinational ALU.
REQ-013 The block SHALL have port o_error, output, 1, one-cycle pulse on a dropped frame.

Function
REQ-014 Frame order SHALL be A byte, B byte, OP byte; FSM states IDLE -> GET_B -> GET_OP -> EXEC -> SEND_RES -> WAIT_RES -> IDLE.
REQ-015 IDLE with i_rx_done SHALL load o_alu_a and go to GET_B; GET_B with i_rx_done SHALL load o_alu_b and go to GET_OP.
REQ-016 GET_OP with i_rx_done SHALL check the opcode: valid means bits [7:6]==0 and [5:0] in {100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR}.
REQ-017 Valid opcode SHALL load o_alu_op and go to EXEC; invalid SHALL leave o_alu_op unchanged, pulse o_error next cycle, and go to IDLE.
REQ-018 EXEC SHALL last exactly one cycle and latch i_alu_result (and i_alu_carry) into the transmit register at its end.
REQ-019 o_tx_start SHALL be high for exactly the one cycle spent in SEND_RES, which is the second cycle after the OP-byte i_rx_done cycle, with o_tx_data holding the result.
REQ-020 WAIT_RES SHALL hold o_tx_data stable until i_tx_done, then leave.
REQ-021 i_rx_done in EXEC, SEND_*, or WAIT_* SHALL be ignored; the byte is dropped and no error is raised.
REQ-022 i_tx_done outside WAIT_* states SHALL be ignored.
REQ-023 A counter SHALL clear on every accepted byte and count in GET_B/GET_OP; reaching TIMEOUT-1 SHALL return to IDLE and pulse o_error; i_rx_done on that same cycle SHALL win (byte accepted, no timeout).
REQ-024 o_alu_a/o_alu_b/o_alu_op SHALL hold their last loaded values between frames.

Reset
REQ-025 On i_reset, FSM SHALL go to IDLE and o_alu_a, o_alu_b, o_alu_op, o_tx_data, the timeout counter, and the carry register SHALL clear to 0.
REQ-026 On i_reset, o_tx_start and o_error SHALL be 0.
REQ-027 Reset SHALL take priority over i_rx_done/i_tx_done in the same cycle and abort any partial frame or pending transmit.

Configuration
REQ-028 Macro ALU_UART_IF_CARRY_TX_EN defined SHALL add states SEND_FLG/WAIT_FLG after WAIT_RES: one more o_tx_start pulse with o_tx_data = {NB_DATA-1 zeros, carry}, awaiting i_tx_done before IDLE.
REQ-029 Macro undefined SHALL omit those states and the carry register; i_alu_carry SHALL be unused and WAIT_RES SHALL go directly to IDLE.

Structure
REQ-030 Opcode localparams (the eight codes) and FSM state encodings SHALL live in shared package alu_pkg, also used by the ALU.
REQ-031 The timeout counter SHALL be sub-module frame_timer (inputs clear and enable; output expire); all other logic SHALL be in alu_uart_if.

Verification
REQ-032 Bytes 0xFF, 0x01, 0x20 -> one o_tx_start 2 cycles after OP byte, o_tx_data=0x00; with macro, a second byte 0x01 after i_tx_done.
REQ-033 Bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE; with macro, the flag byte is 0x01.
REQ-034 Bytes 0x0F, 0xF0, 0x3F (invalid) -> o_error pulse, no o_tx_start, o_alu_op unchanged; next frame 0x0F, 0xF0, 0x25 -> 0xFF.
REQ-035 Byte 0x12, then no byte for TIMEOUT cycles -> o_error pulse, FSM in IDLE; next three bytes form a fresh frame.
REQ-036 Extra i_rx_done during WAIT_RES -> ignored, no state change; i_reset asserted in GET_OP -> all outputs 0, next byte treated as A.
